// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// uart_rx_if: serial line plus received-byte status of an 8N1 UART receiver.
//   uart_rx_i       serial line into the receiver (idle high)
//   uart_rx_data_o  last correctly framed byte
//   uart_rx_done_o  one-cycle pulse, new byte on uart_rx_data_o
//   uart_rx_err_o   one-cycle pulse, framing error (stop bit low)
//   uart_rx_busy_o  receiver is inside a frame
// master: the receiver itself; slave: the line driver / byte consumer.
interface uart_rx_if;
    logic       uart_rx_i;
    logic [7:0] uart_rx_data_o;
    logic       uart_rx_done_o;
    logic       uart_rx_err_o;
    logic       uart_rx_busy_o;

    modport master (
        input  uart_rx_i,
        output uart_rx_data_o,
        output uart_rx_done_o,
        output uart_rx_err_o,
        output uart_rx_busy_o
    );

    modport slave (
        output uart_rx_i,
        input  uart_rx_data_o,
        input  uart_rx_done_o,
        input  uart_rx_err_o,
        input  uart_rx_busy_o
    );
endinterface

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
//   clk_i    system clock, all logic on its rising edge
//   rst_n_i  synchronous active-low reset
//   rx_if    uart_rx_if.master: serial line in, data/done/err/busy out
// The line is synchronised through rx_d0/rx_d1; rx_d2 gives the falling
// edge that starts a frame. The STOP state leaves at mid-stop so a start
// bit immediately following the stop bit is still caught.
module uart_rx #(
    parameter int unsigned SYS_CLK_FRE = 50_000_000,
    parameter int unsigned BPS         = 9_600
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    uart_rx_if.master  rx_if
);
    localparam int unsigned BPS_CNT  = SYS_CLK_FRE / BPS;
    localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_HALF = 16'(BPS_CNT >> 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e      state_q, state_d;
    logic        rx_d0_q, rx_d1_q, rx_d2_q;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic        start_edge;
    logic        sample_pt;
    logic        bit_end;

    always_comb begin
        start_edge = ~rx_d1_q & rx_d2_q;
        sample_pt  = (clk_cnt_q == CNT_HALF);
        bit_end    = (clk_cnt_q == CNT_LAST);

        state_d   = state_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (start_edge) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                // Line back high at mid-start: a glitch, not a start bit.
                if (sample_pt && rx_d1_q) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (sample_pt) begin
                    shift_d[bit_cnt_q] = rx_d1_q;
                end
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (sample_pt) begin
                    state_d   = IDLE;
                    clk_cnt_d = '0;
                    if (rx_d1_q) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            rx_d0_q   <= 1'b1;
            rx_d1_q   <= 1'b1;
            rx_d2_q   <= 1'b1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_d0_q   <= rx_if.uart_rx_i;
            rx_d1_q   <= rx_d0_q;
            rx_d2_q   <= rx_d1_q;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_if.uart_rx_data_o = data_q;
    assign rx_if.uart_rx_done_o = done_q;
    assign rx_if.uart_rx_err_o  = err_q;
    assign rx_if.uart_rx_busy_o = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    localparam int  SYS_CLK = 1_600_000;
    localparam int  BAUD    = 100_000;
    localparam int  BPS_CNT = SYS_CLK / BAUD;
    localparam int  HALF    = BPS_CNT / 2;
    localparam int  LAT     = 9 * BPS_CNT + HALF + 3;
    localparam real CLK_NS  = 10.0;
    localparam real BIT_NS  = CLK_NS * BPS_CNT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx_line = 1'b1;

    uart_rx_if u_if ();
    assign u_if.uart_rx_i = rx_line;

    uart_rx #(.SYS_CLK_FRE(SYS_CLK), .BPS(BAUD)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .rx_if   (u_if)
    );

    always #(CLK_NS / 2.0) clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every pulse and busy transition, sampled on negedge.
    logic [7:0] done_data_q[$];
    int         done_cyc_q[$];
    int         err_cyc_q[$];
    int         busy_rise = 0;
    int         busy_fall_cyc = -1;
    int         overlap_cnt = 0;
    int         long_pulse_cnt = 0;
    logic       prev_done = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (u_if.uart_rx_done_o === 1'b1) begin
            done_data_q.push_back(u_if.uart_rx_data_o);
            done_cyc_q.push_back(cyc);
        end
        if (u_if.uart_rx_err_o === 1'b1) err_cyc_q.push_back(cyc);
        if (u_if.uart_rx_done_o === 1'b1 && u_if.uart_rx_err_o === 1'b1) overlap_cnt++;
        if ((u_if.uart_rx_done_o === 1'b1 && prev_done) ||
            (u_if.uart_rx_err_o === 1'b1 && prev_err)) long_pulse_cnt++;
        if (u_if.uart_rx_busy_o === 1'b1 && !prev_busy) busy_rise++;
        if (u_if.uart_rx_busy_o === 1'b0 && prev_busy) busy_fall_cyc = cyc;
        prev_done = (u_if.uart_rx_done_o === 1'b1);
        prev_err  = (u_if.uart_rx_err_o === 1'b1);
        prev_busy = (u_if.uart_rx_busy_o === 1'b1);
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_good = 8'h00;   // model: byte the output must hold
    int         frame_cyc = 0;

    task automatic clear_mon();
        @(posedge clk);
        done_data_q.delete();
        done_cyc_q.delete();
        err_cyc_q.delete();
        busy_rise     = 0;
        busy_fall_cyc = -1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns);
        rx_line   = 1'b0;
        frame_cyc = cyc;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            #(bit_ns);
        end
        rx_line = stop;
        #(bit_ns);
        rx_line = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (u_if.uart_rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", u_if.uart_rx_data_o); end
        checks++; if (u_if.uart_rx_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", u_if.uart_rx_done_o); end
        checks++; if (u_if.uart_rx_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", u_if.uart_rx_err_o); end
        checks++; if (u_if.uart_rx_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", u_if.uart_rx_busy_o); end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_basic();
        int lat;
        clear_mon();
        #3;
        send_frame(8'h55, 1'b1, BIT_NS);
        last_good = 8'h55;
        repeat (20) @(posedge clk);
        checks++; if (done_data_q.size() !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_data_q.size()); end
        checks++; if (done_data_q[0] !== 8'h55) begin errors++; $display("FAIL basic_done_data: got %02h expected 55", done_data_q[0]); end
        checks++; if (err_cyc_q.size() !== 0) begin errors++; $display("FAIL basic_err_count: got %0d expected 0", err_cyc_q.size()); end
        checks++; if (u_if.uart_rx_data_o !== 8'h55) begin errors++; $display("FAIL basic_data_hold: got %02h expected 55", u_if.uart_rx_data_o); end
        lat = done_cyc_q[0] - frame_cyc;
        checks++; if (lat < LAT || lat > LAT + 2) begin errors++; $display("FAIL basic_latency: got %0d expected %0d..%0d", lat, LAT, LAT + 2); end
        checks++; if (busy_rise !== 1) begin errors++; $display("FAIL basic_busy_rise: got %0d expected 1", busy_rise); end
        checks++; if (busy_fall_cyc < done_cyc_q[0] - 1 || busy_fall_cyc > done_cyc_q[0] + 1) begin
            errors++; $display("FAIL basic_busy_fall: got cycle %0d expected %0d+/-1", busy_fall_cyc, done_cyc_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_mon();
        #3;
        send_frame(8'hA3, 1'b1, BIT_NS);
        send_frame(8'h0F, 1'b1, BIT_NS);
        last_good = 8'h0F;
        repeat (20) @(posedge clk);
        checks++; if (done_data_q.size() !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_data_q.size()); end
        checks++; if (done_data_q[0] !== 8'hA3) begin errors++; $display("FAIL b2b_first: got %02h expected a3", done_data_q[0]); end
        checks++; if (done_data_q[1] !== 8'h0F) begin errors++; $display("FAIL b2b_second: got %02h expected 0f", done_data_q[1]); end
        gap = done_cyc_q[1] - done_cyc_q[0];
        checks++; if (gap < 10 * BPS_CNT - 1 || gap > 10 * BPS_CNT + 1) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d+/-1", gap, 10 * BPS_CNT); end
        checks++; if (err_cyc_q.size() !== 0) begin errors++; $display("FAIL b2b_err_count: got %0d expected 0", err_cyc_q.size()); end
    endtask

    task automatic test_glitch();
        int start_c, d;
        clear_mon();
        #3;
        rx_line = 1'b0;
        start_c = cyc;
        #(CLK_NS * (BPS_CNT / 4));
        rx_line = 1'b1;
        repeat (3 * BPS_CNT) @(posedge clk);
        #1;
        checks++; if (busy_rise !== 1) begin errors++; $display("FAIL glitch_busy_rise: got %0d expected 1", busy_rise); end
        checks++; if (u_if.uart_rx_busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", u_if.uart_rx_busy_o); end
        d = busy_fall_cyc - start_c;
        checks++; if (d < HALF + 2 || d > HALF + 6) begin errors++; $display("FAIL glitch_busy_fall: got %0d cycles expected %0d..%0d", d, HALF + 2, HALF + 6); end
        checks++; if (done_data_q.size() !== 0) begin errors++; $display("FAIL glitch_done: got %0d expected 0", done_data_q.size()); end
        checks++; if (err_cyc_q.size() !== 0) begin errors++; $display("FAIL glitch_err: got %0d expected 0", err_cyc_q.size()); end
        checks++; if (u_if.uart_rx_data_o !== last_good) begin errors++; $display("FAIL glitch_data_hold: got %02h expected %02h", u_if.uart_rx_data_o, last_good); end
    endtask

    task automatic test_framing_error();
        int lat;
        clear_mon();
        #3;
        send_frame(8'hC6, 1'b0, BIT_NS);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (err_cyc_q.size() !== 1) begin errors++; $display("FAIL ferr_err_count: got %0d expected 1", err_cyc_q.size()); end
        checks++; if (done_data_q.size() !== 0) begin errors++; $display("FAIL ferr_done_count: got %0d expected 0", done_data_q.size()); end
        checks++; if (u_if.uart_rx_data_o !== last_good) begin errors++; $display("FAIL ferr_data_hold: got %02h expected %02h", u_if.uart_rx_data_o, last_good); end
        lat = err_cyc_q[0] - frame_cyc;
        checks++; if (lat < LAT || lat > LAT + 2) begin errors++; $display("FAIL ferr_latency: got %0d expected %0d..%0d", lat, LAT, LAT + 2); end

        // Break: line low for well over a frame, one err, no restart while low.
        clear_mon();
        #3;
        rx_line = 1'b0;
        #(BIT_NS * 13.0);
        checks++; if (err_cyc_q.size() !== 1) begin errors++; $display("FAIL break_err_count: got %0d expected 1", err_cyc_q.size()); end
        checks++; if (u_if.uart_rx_busy_o !== 1'b0) begin errors++; $display("FAIL break_busy: got %b expected 0", u_if.uart_rx_busy_o); end
        #(BIT_NS * 12.0);
        rx_line = 1'b1;
        #(BIT_NS * 2.0);
        checks++; if (err_cyc_q.size() !== 1) begin errors++; $display("FAIL break_no_restart: got %0d err pulses expected 1", err_cyc_q.size()); end
        checks++; if (done_data_q.size() !== 0) begin errors++; $display("FAIL break_done: got %0d expected 0", done_data_q.size()); end
        checks++; if (u_if.uart_rx_data_o !== last_good) begin errors++; $display("FAIL break_data_hold: got %02h expected %02h", u_if.uart_rx_data_o, last_good); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] aborted;
        // Upper nibble high: no falling edge on the line after the abort.
        aborted = 8'hF0 | 8'($urandom_range(15, 0));
        clear_mon();
        #3;
        fork
            send_frame(aborted, 1'b1, BIT_NS);
            begin
                #(BIT_NS * 5.5);
                @(posedge clk);
                #1 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        last_good = 8'h00;
        repeat (2 * BPS_CNT) @(posedge clk);
        #1;
        checks++; if (done_data_q.size() !== 0) begin errors++; $display("FAIL rstmid_done: got %0d expected 0", done_data_q.size()); end
        checks++; if (err_cyc_q.size() !== 0) begin errors++; $display("FAIL rstmid_err: got %0d expected 0", err_cyc_q.size()); end
        checks++; if (u_if.uart_rx_busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", u_if.uart_rx_busy_o); end
        checks++; if (u_if.uart_rx_data_o !== last_good) begin errors++; $display("FAIL rstmid_data_cleared: got %02h expected %02h", u_if.uart_rx_data_o, last_good); end

        clear_mon();
        #3;
        send_frame(8'h3C, 1'b1, BIT_NS);
        last_good = 8'h3C;
        repeat (20) @(posedge clk);
        checks++; if (done_data_q.size() !== 1) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", done_data_q.size()); end
        checks++; if (done_data_q[0] !== 8'h3C) begin errors++; $display("FAIL rstmid_next_data: got %02h expected 3c", done_data_q[0]); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        real        bit_ns;
        int         off, n;
        clear_mon();
        for (int k = 0; k < 256; k++) begin
            b      = 8'($urandom_range(255, 0));
            off    = int'($urandom_range(4000, 0)) - 2000;   // +/-2.000 %
            bit_ns = BIT_NS * (1.0 + off / 100000.0);
            #($urandom_range(9999, 0) / 1000.0);
            if ($urandom_range(3, 0) != 0) #(CLK_NS * $urandom_range(20, 1));
            send_frame(b, 1'b1, bit_ns);
            exp_q.push_back(b);
        end
        last_good = exp_q[exp_q.size() - 1];
        repeat (2 * BPS_CNT) @(posedge clk);
        checks++; if (done_data_q.size() !== 256) begin errors++; $display("FAIL rand_done_count: got %0d expected 256", done_data_q.size()); end
        checks++; if (err_cyc_q.size() !== 0) begin errors++; $display("FAIL rand_err_count: got %0d expected 0", err_cyc_q.size()); end
        n = (done_data_q.size() < 256) ? done_data_q.size() : 256;
        for (int k = 0; k < n; k++) begin
            checks++; if (done_data_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_byte_%0d: got %02h expected %02h", k, done_data_q[k], exp_q[k]); end
        end
        checks++; if (u_if.uart_rx_data_o !== last_good) begin errors++; $display("FAIL rand_data_hold: got %02h expected %02h", u_if.uart_rx_data_o, last_good); end
    endtask

    task automatic test_pulse_rules();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d cycles with done and err expected 0", overlap_cnt); end
        checks++; if (long_pulse_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d over-long pulse cycles expected 0", long_pulse_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_midframe();
        test_random();
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
